// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 master.
package apb4_master_pkg;

  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] TIMEOUT_DEFAULT = 16'd255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage : apb4_master_pkg

// File: rtl/dffr.sv
// Generic register: asynchronous active-low reset to zero, synchronous load enable.
module dffr #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Reset clears, otherwise load when enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : dffr

// File: rtl/apb4_master.sv
// APB4 master: turns one command at a time into an APB4 transfer and returns a response.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for a command; cmd_ready_o high
// ST_SETUP  | APB setup phase, psel=1 penable=0, exactly one cycle
// ST_ACCESS | APB access phase, psel=1 penable=1, wait for pready or timeout
// ST_RESP   | response held on rsp_* until rsp_ready_i
module apb4_master
  import apb4_master_pkg::*;
#(
  parameter int               ADDR_WIDTH = 32,
  parameter int               DATA_WIDTH = 32,
  parameter logic [CNT_W-1:0] TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int STRB_W = DATA_WIDTH / 8;

  apb_state_e state_q, state_d;
  logic [1:0] state_bits_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             tmo_hit;

  logic ready_q, ready_d;
  logic psel_q, psel_d;
  logic penable_q, penable_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic rsp_err_q, rsp_err_d;
  logic rsp_tmo_q, rsp_tmo_d;

  logic                  lat_en;
  logic [DATA_WIDTH-1:0] wdata_lat_d;
  logic [STRB_W-1:0]     strb_lat_d;

  assign state_q = apb_state_e'(state_bits_q);

  // Read transfers carry no write payload on the bus.
  assign wdata_lat_d = cmd_write_i ? cmd_wdata_i : '0;
  assign strb_lat_d  = cmd_write_i ? cmd_strb_i  : '0;

  // The count including the current stalled cycle is what gets compared to the limit.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign tmo_hit = (TIMEOUT != '0) && (cnt_inc == {1'b0, TIMEOUT});

  // Next-state, bus-phase and response decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    lat_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid_i && ready_q) begin
          state_d   = ST_SETUP;
          lat_en    = 1'b1;
          ready_d   = 1'b0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_o ? '0 : prdata_i;
          rsp_err_d   = pslverr_i;
          rsp_tmo_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
        end else if (!cnt_inc[CNT_W]) begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          ready_d     = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  dffr #(.WIDTH(2))          u_state   (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(state_d),     .q_o(state_bits_q));
  dffr #(.WIDTH(CNT_W))      u_cnt     (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(cnt_d),       .q_o(cnt_q));
  dffr #(.WIDTH(1))          u_ready   (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(ready_d),     .q_o(ready_q));
  dffr #(.WIDTH(1))          u_psel    (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(psel_d),      .q_o(psel_q));
  dffr #(.WIDTH(1))          u_penable (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(penable_d),   .q_o(penable_q));
  dffr #(.WIDTH(1))          u_rvalid  (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(rsp_valid_d), .q_o(rsp_valid_q));
  dffr #(.WIDTH(DATA_WIDTH)) u_rdata   (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(rsp_rdata_d), .q_o(rsp_rdata_q));
  dffr #(.WIDTH(1))          u_rerr    (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(rsp_err_d),   .q_o(rsp_err_q));
  dffr #(.WIDTH(1))          u_rtmo    (.clk_i(hclk), .rst_ni(hresetn), .en_i(1'b1), .d_i(rsp_tmo_d),   .q_o(rsp_tmo_q));

  // Command fields are captured once at acceptance and drive the bus directly.
  dffr #(.WIDTH(ADDR_WIDTH)) u_paddr   (.clk_i(hclk), .rst_ni(hresetn), .en_i(lat_en), .d_i(cmd_addr_i),  .q_o(paddr_o));
  dffr #(.WIDTH(3))          u_pprot   (.clk_i(hclk), .rst_ni(hresetn), .en_i(lat_en), .d_i(cmd_prot_i),  .q_o(pprot_o));
  dffr #(.WIDTH(1))          u_pwrite  (.clk_i(hclk), .rst_ni(hresetn), .en_i(lat_en), .d_i(cmd_write_i), .q_o(pwrite_o));
  dffr #(.WIDTH(DATA_WIDTH)) u_pwdata  (.clk_i(hclk), .rst_ni(hresetn), .en_i(lat_en), .d_i(wdata_lat_d), .q_o(pwdata_o));
  dffr #(.WIDTH(STRB_W))     u_pstrb   (.clk_i(hclk), .rst_ni(hresetn), .en_i(lat_en), .d_i(strb_lat_d),  .q_o(pstrb_o));

  assign cmd_ready_o   = ready_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_tmo_q;

endmodule : apb4_master

// File: tb/tb_apb4_master.sv
// Bench for apb4_master: directed table, hand-written reset sequence, randomized transfers.
module tb_apb4_master;

  localparam int TMO = 4;

  logic        hclk;
  logic        hresetn;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic [2:0]  cmd_prot_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int n_total = 0;
  int n_pass  = 0;

  apb4_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (16'(TMO))
  ) dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .cmd_strb_i   (cmd_strb_i),
    .cmd_prot_i   (cmd_prot_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .paddr_o      (paddr_o),
    .pprot_o      (pprot_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_n;
    logic [31:0] prd;
    logic        slverr;
    int          delay;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_tmo;
    int          e_acc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level expectation: stalls beyond the limit end as a timeout.
  function automatic void model(input logic wr, input int wait_n, input logic [31:0] prd,
                                input logic sl, output logic [31:0] rd, output logic err,
                                output logic tmo, output int acc);
    if (wait_n >= TMO) begin
      acc = TMO; rd = '0; err = 1'b1; tmo = 1'b1;
    end else begin
      acc = wait_n + 1; rd = wr ? 32'h0 : prd; err = sl; tmo = 1'b0;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input vec_t v);
    logic [31:0] exp_wd;
    logic [3:0]  exp_sb;
    exp_wd = v.wr ? v.wdata : 32'h0;
    exp_sb = v.wr ? v.strb  : 4'h0;
    chk("idle_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_write_i = v.wr;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    cmd_strb_i  = v.strb;
    cmd_prot_i  = v.prot;
    @(negedge hclk);
    cmd_valid_i = 1'b0;
    cmd_write_i = ~v.wr;
    cmd_addr_i  = $urandom;
    cmd_wdata_i = $urandom;
    cmd_strb_i  = 4'($urandom);
    cmd_prot_i  = 3'($urandom);
    pready_i    = 1'($urandom);
    chk("setup_psel", psel_o, 1);
    chk("setup_penable", penable_o, 0);
    chk("setup_paddr", paddr_o, v.addr);
    chk("setup_pwrite", pwrite_o, v.wr);
    chk("setup_pwdata", pwdata_o, exp_wd);
    chk("setup_pstrb", pstrb_o, exp_sb);
    chk("setup_pprot", pprot_o, v.prot);
    chk("setup_ready", cmd_ready_o, 0);
    chk("setup_rvalid", rsp_valid_o, 0);
    for (int k = 0; k < v.e_acc; k++) begin
      @(negedge hclk);
      chk("acc_psel", psel_o, 1);
      chk("acc_penable", penable_o, 1);
      chk("acc_paddr", paddr_o, v.addr);
      chk("acc_pwrite", pwrite_o, v.wr);
      chk("acc_pwdata", pwdata_o, exp_wd);
      chk("acc_pstrb", pstrb_o, exp_sb);
      chk("acc_pprot", pprot_o, v.prot);
      chk("acc_rvalid", rsp_valid_o, 0);
      if (k == v.wait_n) begin
        pready_i = 1'b1; prdata_i = v.prd; pslverr_i = v.slverr;
      end else begin
        pready_i = 1'b0; prdata_i = $urandom; pslverr_i = 1'($urandom);
      end
    end
    @(negedge hclk);
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
    chk("resp_valid", rsp_valid_o, 1);
    chk("resp_psel", psel_o, 0);
    chk("resp_penable", penable_o, 0);
    chk("resp_rdata", rsp_rdata_o, v.e_rdata);
    chk("resp_err", rsp_err_o, v.e_err);
    chk("resp_tmo", rsp_timeout_o, v.e_tmo);
    chk("resp_ready", cmd_ready_o, 0);
    for (int d = 0; d < v.delay; d++) begin
      rsp_ready_i = 1'b0;
      cmd_valid_i = 1'b1;
      @(negedge hclk);
      chk("stall_valid", rsp_valid_o, 1);
      chk("stall_rdata", rsp_rdata_o, v.e_rdata);
      chk("stall_err", rsp_err_o, v.e_err);
      chk("stall_tmo", rsp_timeout_o, v.e_tmo);
      chk("stall_psel", psel_o, 0);
      chk("stall_ready", cmd_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b0;
    @(negedge hclk);
    rsp_ready_i = 1'b0;
    chk("done_valid", rsp_valid_o, 0);
    chk("done_ready", cmd_ready_o, 1);
    chk("done_psel", psel_o, 0);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 3'd0, 0,  32'h0,         1'b0, 0, 32'h0,         1'b0, 1'b0, 1};
    tbl[1] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 3'd0, 3,  32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
    tbl[2] = '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'h3, 3'd5, 1,  32'h0,         1'b1, 1, 32'h0,         1'b1, 1'b0, 2};
    tbl[3] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 3'd1, 10, 32'h1111_2222, 1'b0, 0, 32'h0,         1'b1, 1'b1, 4};
    tbl[4] = '{1'b1, 32'h0000_0024, 32'hCAFE_0001, 4'h9, 3'd7, 10, 32'h0,         1'b0, 5, 32'h0,         1'b1, 1'b1, 4};
    tbl[5] = '{1'b0, 32'h0000_0030, 32'h7777_7777, 4'hC, 3'd2, 2,  32'h0BAD_F00D, 1'b1, 5, 32'h0BAD_F00D, 1'b1, 1'b0, 3};

    hresetn = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_wdata_i = '0; cmd_strb_i = '0; cmd_prot_i = '0; rsp_ready_i = 1'b0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;

    @(negedge hclk);
    @(negedge hclk);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_rvalid", rsp_valid_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_ready", cmd_ready_o, 0);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("post_rst_ready", cmd_ready_o, 1);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Reset in the middle of an access phase.
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h0000_0040;
    cmd_prot_i = 3'd3; cmd_strb_i = 4'h0; cmd_wdata_i = '0;
    @(negedge hclk);
    cmd_valid_i = 1'b0; pready_i = 1'b0;
    @(negedge hclk);
    chk("mid_acc_penable", penable_o, 1);
    #1 hresetn = 1'b0;
    #1;
    chk("mid_rst_psel", psel_o, 0);
    chk("mid_rst_penable", penable_o, 0);
    chk("mid_rst_rvalid", rsp_valid_o, 0);
    chk("mid_rst_paddr", paddr_o, 0);
    chk("mid_rst_pprot", pprot_o, 0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("mid_post_ready", cmd_ready_o, 1);
    chk("mid_post_psel", psel_o, 0);
    rv = '{1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'd0, 1, 32'h55AA_55AA, 1'b0, 0, 32'h55AA_55AA, 1'b0, 1'b0, 2};
    run_txn(rv);

    for (int i = 0; i < 60; i++) begin
      rv.wr     = 1'($urandom);
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.strb   = 4'($urandom);
      rv.prot   = 3'($urandom);
      rv.wait_n = int'($urandom_range(0, 7));
      rv.prd    = $urandom;
      rv.slverr = 1'($urandom);
      rv.delay  = int'($urandom_range(0, 3));
      model(rv.wr, rv.wait_n, rv.prd, rv.slverr, rv.e_rdata, rv.e_err, rv.e_tmo, rv.e_acc);
      run_txn(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_apb4_master
